uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
//
// PURPOSE
//   Packet-atomic round-robin arbiter that shares one uart_tx serializer among
//   NUM_REQ byte-stream requesters (debug console, test harness, status dumps).
//   Sits between the requesters and uart_tx: drives tx_data/tx_req, consumes
//   tx_cts/tx_idle. A granted requester keeps the UART until its last byte.
//
// PARAMETERS
//   NUM_REQ   4   number of requesters, 2..16
//   ID_BITS   $clog2(NUM_REQ) (localparam)   width of grant_id
//
// PORTS
//   clk        in   1          clock
//   rst_n      in   1          asynchronous reset, active low
//   req_valid  in   NUM_REQ    requester i has a byte on req_data[i]
//   req_data   in   NUM_REQ*8  byte of requester i at [8*i +: 8]
//   req_last   in   NUM_REQ    byte of requester i ends its packet
//   req_ready  out  NUM_REQ    byte of requester i consumed this cycle
//   tx_data    out  8          byte to uart_tx
//   tx_req     out  1          byte request to uart_tx
//   tx_cts     in   1          uart_tx accepts a byte at this edge if tx_req
//   tx_idle    in   1          uart_tx fully idle (line back to stop level)
//   grant_id   out  ID_BITS    current/last granted requester
//   busy       out  1          arbiter not IDLE or uart_tx not idle
//
// BEHAVIOUR
//   - Transfer = tx_req && tx_cts at posedge. Only the granted requester sees
//     req_ready; req_ready[g] = (state==SEND) && grant==g && tx_cts.
//   - States: IDLE, HDR (tag build only), SEND.
//   - IDLE: tx_req=0. If any req_valid: pick first valid at or after rr_ptr
//     (wrapping modulo NUM_REQ), register grant; next state HDR (tag) else SEND.
//     First tx_req is one cycle after req_valid is seen in IDLE.
//   - SEND: tx_data = req_data[grant]; tx_req = req_valid[grant]. Transfer with
//     req_last[grant] -> IDLE, rr_ptr <= grant+1 (wraps to 0 past NUM_REQ-1).
//     Transfer without last -> stay. Granted valid low mid-packet: tx_req=0,
//     grant held, other requesters ignored (no timeout).
//   - tx_data/tx_req combinational from grant and req_*; no bytes buffered.
//   - Ungranted req_valid never affects outputs; one-byte packets are legal.
//   - Simultaneous requests: strict rotation, each requester served at most
//     once per rotation when all request continuously.
//   - Reset (any time, incl. mid-packet): state=IDLE, grant_id=0, rr_ptr=0,
//     tx_req=0, req_ready=0, tx_data=0; busy follows tx_idle (uart_tx also
//     reset -> busy=1 while rst_n low since tx_idle=0 in reset).
//
// CONFIGURATION
//   UART_TX_ARBITER_TAG_EN defined: after grant, state HDR sends one tag byte
//   8'hF0 | grant (tx_req=1, req_ready=0); its transfer -> SEND. Undefined:
//   no HDR state, IDLE -> SEND directly, byte stream unmodified.
//
// STRUCTURE
//   uart_arb_pkg: state enum (IDLE/HDR/SEND), TAG_BASE = 8'hF0, MAX_REQ = 16.
//   Sub-module uart_rr_pick: combinational round-robin picker
//   (valid vector + pointer -> found flag + index); rest in uart_tx_arbiter.
//
// TESTING (NUM_REQ=4, driving a real uart_tx, clocks_per_bit=4)
//   1. req0 sends 3 bytes 41,42,43(last) -> SER_TX shows 41,42,43 in order,
//      one req_ready[0] pulse per byte, busy drops after final stop bits.
//   2. req1,req3 both valid, 2-byte packets -> req1 packet complete before any
//      req3 byte; next contention with req1 again -> req3 wins (rr_ptr=2).
//   3. All four valid continuously, 1-byte packets -> grants 0,1,2,3,0,...
//   4. req2 drops valid after byte 1 of 3 while req0 valid -> tx_req=0, grant
//      stays 2; req2 resumes -> remaining bytes sent before req0's.
//   5. Reset asserted mid-packet of req1 -> tx_req=0, grant_id=0 immediately;
//      after release req1 restarts arbitration from rr_ptr=0.
//   6. TAG_EN, req3 sends 1 byte 55 -> line shows F3 then 55.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared constants for the packet-atomic UART transmit arbiter.
// Defines FSM state encodings, the tag base byte and the requester limit.
package uart_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [7:0] TAG_BASE = 8'hF0;
    localparam int         MAX_REQ  = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx byte handshake.
// The master modport is the arbiter's view; slave is the requester/uart_tx side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_req;
    logic                 tx_cts;
    logic                 tx_idle;

    modport master (
        input  req_valid, req_data, req_last, tx_cts, tx_idle,
        output req_ready, tx_data, tx_req
    );

    modport slave (
        output req_valid, req_data, req_last, tx_cts, tx_idle,
        input  req_ready, tx_data, tx_req
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set bit of valid at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int ID_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_BITS-1:0] ptr,
    output logic               found,
    output logic [ID_BITS-1:0] idx
);
    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                idx   = ID_BITS'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin share of one uart_tx; optional tag byte via UART_TX_ARBITER_TAG_EN.
// Latency: first tx_req one cycle after a request is seen idle; data/req pass through combinationally.
// Backpressure: tx_cts gates req_ready of the granted requester only; others wait.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_BITS = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_arbiter_if.master      bus,
    output logic [ID_BITS-1:0]     grant_id,
    output logic                   busy
);
    logic [1:0]         state_q, state_d;
    logic [ID_BITS-1:0] grant_q, grant_d;
    logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic               pick_found;
    logic [ID_BITS-1:0] pick_idx;
    logic [7:0]         gnt_data;
    logic               gnt_valid;
    logic               gnt_last;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign gnt_data  = bus.req_data[{grant_q, 3'b000} +: 8];
    assign gnt_valid = bus.req_valid[grant_q];
    assign gnt_last  = bus.req_last[grant_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        bus.tx_req    = 1'b0;
        bus.tx_data   = 8'h00;
        bus.req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
`ifdef UART_TX_ARBITER_TAG_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_SEND;
`endif
                end
            end
`ifdef UART_TX_ARBITER_TAG_EN
            ST_HDR: begin
                bus.tx_req  = 1'b1;
                bus.tx_data = TAG_BASE | 8'(grant_q);
                if (bus.tx_cts) state_d = ST_SEND;
            end
`endif
            ST_SEND: begin
                bus.tx_req             = gnt_valid;
                bus.tx_data            = gnt_data;
                bus.req_ready[grant_q] = bus.tx_cts;
                // Grant is held across valid gaps; only the last byte releases it.
                if (gnt_valid && bus.tx_cts && gnt_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == ID_BITS'(NUM_REQ - 1)) ? '0
                                                                  : grant_q + ID_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE) || !bus.tx_idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4); bench drives tx_cts/tx_idle directly.
// Tag-byte sequence runs instead when UART_TX_ARBITER_TAG_EN is defined.
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       busy;
    int         checks = 0;
    int         failures = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[i]        = v;
        bus.req_data[8*i +: 8]  = d;
        bus.req_last[i]         = l;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_cts    = 1'b1;
        bus.tx_idle   = 1'b0;
        cyc();
        cyc();
        check("rst_tx_req", 32'(bus.tx_req), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        rst_n       = 1'b1;
        bus.tx_idle = 1'b1;
        #1;
        check("idle_busy", 32'(busy), 32'd0);

`ifdef UART_TX_ARBITER_TAG_EN
        set_req(3, 1'b1, 8'h55, 1'b1);
        cyc();
        check("tag_byte", 32'(bus.tx_data), 32'hF3);
        check("tag_req", 32'(bus.tx_req), 32'd1);
        check("tag_ready", 32'(bus.req_ready), 32'd0);
        cyc();
        check("tag_payload", 32'(bus.tx_data), 32'h55);
        check("tag_pay_ready", 32'(bus.req_ready), 32'h8);
        cyc();
        set_req(3, 1'b0, 8'h00, 1'b0);
        #1;
        check("tag_done", 32'(bus.tx_req), 32'd0);
`else
        // Single requester, three-byte packet.
        set_req(0, 1'b1, 8'h41, 1'b0);
        #1;
        check("t1_idle_req", 32'(bus.tx_req), 32'd0);
        cyc();
        check("t1_req", 32'(bus.tx_req), 32'd1);
        check("t1_b0", 32'(bus.tx_data), 32'h41);
        check("t1_ready0", 32'(bus.req_ready), 32'h1);
        check("t1_grant", 32'(grant_id), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        cyc();
        set_req(0, 1'b1, 8'h42, 1'b0);
        #1;
        check("t1_b1", 32'(bus.tx_data), 32'h42);
        cyc();
        set_req(0, 1'b1, 8'h43, 1'b1);
        #1;
        check("t1_b2", 32'(bus.tx_data), 32'h43);
        check("t1_ready2", 32'(bus.req_ready), 32'h1);
        cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("t1_end_req", 32'(bus.tx_req), 32'd0);
        bus.tx_idle = 1'b0;
        #1;
        check("t1_busy_uart", 32'(busy), 32'd1);
        bus.tx_idle = 1'b1;
        #1;
        check("t1_busy_off", 32'(busy), 32'd0);

        // req1 and req3 contend; rr_ptr=1 so req1 first, with a cts stall.
        set_req(1, 1'b1, 8'h11, 1'b0);
        set_req(3, 1'b1, 8'h31, 1'b0);
        cyc();
        check("t2_grant1", 32'(grant_id), 32'd1);
        check("t2_b11", 32'(bus.tx_data), 32'h11);
        bus.tx_cts = 1'b0;
        #1;
        check("t2_stall_ready", 32'(bus.req_ready), 32'd0);
        check("t2_stall_req", 32'(bus.tx_req), 32'd1);
        cyc();
        check("t2_hold", 32'(bus.tx_data), 32'h11);
        bus.tx_cts = 1'b1;
        #1;
        check("t2_ready1", 32'(bus.req_ready), 32'h2);
        cyc();
        set_req(1, 1'b1, 8'h12, 1'b1);
        #1;
        check("t2_b12", 32'(bus.tx_data), 32'h12);
        cyc();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1;
        check("t2_gap", 32'(bus.tx_req), 32'd0);
        cyc();
        check("t2_grant3", 32'(grant_id), 32'd3);
        check("t2_b31", 32'(bus.tx_data), 32'h31);
        cyc();
        set_req(3, 1'b1, 8'h32, 1'b1);
        cyc();
        set_req(1, 1'b1, 8'h13, 1'b1);
        set_req(3, 1'b1, 8'h33, 1'b1);
        cyc();
        check("t2_wrap_grant1", 32'(grant_id), 32'd1);
        check("t2_b13", 32'(bus.tx_data), 32'h13);
        cyc();
        cyc();
        check("t2_rr_grant3", 32'(grant_id), 32'd3);
        check("t2_b33", 32'(bus.tx_data), 32'h33);
        cyc();
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b0, 8'h00, 1'b0);

        // All four requesting one-byte packets continuously; rr_ptr=0.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t3_idle", 32'(bus.tx_req), 32'd0);
            cyc();
            check("t3_grant", 32'(grant_id), 32'(i % 4));
            check("t3_data", 32'(bus.tx_data), 32'hA0 + 32'(i % 4));
            check("t3_ready", 32'(bus.req_ready), 32'd1 << (i % 4));
            cyc();
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h00, 1'b0);

        // req2 pauses mid-packet while req0 waits; rr_ptr=0.
        set_req(2, 1'b1, 8'h21, 1'b0);
        cyc();
        check("t4_grant2", 32'(grant_id), 32'd2);
        cyc();
        set_req(2, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h01, 1'b1);
        #1;
        check("t4_gap_req", 32'(bus.tx_req), 32'd0);
        check("t4_gap_ready", 32'(bus.req_ready), 32'h4);
        cyc();
        check("t4_hold_grant", 32'(grant_id), 32'd2);
        check("t4_hold_req", 32'(bus.tx_req), 32'd0);
        set_req(2, 1'b1, 8'h22, 1'b0);
        #1;
        check("t4_resume", 32'(bus.tx_data), 32'h22);
        check("t4_resume_req", 32'(bus.tx_req), 32'd1);
        cyc();
        set_req(2, 1'b1, 8'h23, 1'b1);
        #1;
        check("t4_b23", 32'(bus.tx_data), 32'h23);
        cyc();
        set_req(2, 1'b0, 8'h00, 1'b0);
        cyc();
        check("t4_grant0", 32'(grant_id), 32'd0);
        check("t4_b01", 32'(bus.tx_data), 32'h01);
        cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);

        // Reset in the middle of req1's packet; rr_ptr=1.
        set_req(1, 1'b1, 8'h51, 1'b0);
        set_req(3, 1'b1, 8'h53, 1'b0);
        cyc();
        check("t5_grant1", 32'(grant_id), 32'd1);
        cyc();
        set_req(1, 1'b1, 8'h52, 1'b0);
        rst_n       = 1'b0;
        bus.tx_idle = 1'b0;
        #1;
        check("t5_rst_req", 32'(bus.tx_req), 32'd0);
        check("t5_rst_grant", 32'(grant_id), 32'd0);
        check("t5_rst_data", 32'(bus.tx_data), 32'd0);
        check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd1);
        cyc();
        rst_n       = 1'b1;
        bus.tx_idle = 1'b1;
        #1;
        cyc();
        check("t5_restart_grant", 32'(grant_id), 32'd1);
        check("t5_restart_data", 32'(bus.tx_data), 32'h52);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
